// File: rtl/sng_array.sv
// Multi-channel stochastic number generator: CH operands become CH unipolar
// bitstreams of length 2^WIDTH, sourced from a shared de Bruijn LFSR or a ramp.
module sng_array #(
    parameter int WIDTH = 4,
    parameter int CH    = 4,
    parameter int SEED  = 1
) (
    input  logic                  i_clk_sng,
    input  logic                  i_rst_sng,
    input  logic                  i_start_sng,
    input  logic                  i_stop_sng,
    input  logic                  i_mode_sng,
    input  logic [CH*WIDTH-1:0]   i_x_bn,
    output logic [CH-1:0]         o_sn_bits,
    output logic                  o_valid_sng,
    output logic                  o_done_sng,
    output logic                  o_busy_sng
);

    localparam int               LEN    = 1 << WIDTH;
    localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] LAST   = WIDTH'(LEN - 1);
    localparam logic [7:0]       TAPS8  = (WIDTH == 3) ? 8'h06 :
                                          (WIDTH == 4) ? 8'h0C :
                                          (WIDTH == 5) ? 8'h14 :
                                          (WIDTH == 6) ? 8'h30 :
                                          (WIDTH == 7) ? 8'h60 : 8'hB8;
    localparam logic [WIDTH-1:0] TAPS   = TAPS8[WIDTH-1:0];

    typedef enum logic {IDLE, RUN} state_t;

    // The zero-detect term splices the all-zero state into the maximal cycle.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        logic fb;
        fb = (^(s & TAPS)) ^ (s[WIDTH-2:0] == '0);
        return {s[WIDTH-2:0], fb};
    endfunction

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int sh);
        logic [2*WIDTH-1:0] d;
        d = {v, v} << sh;
        return d[2*WIDTH-1:WIDTH];
    endfunction

    state_t                state, state_nx;
    logic [WIDTH-1:0]      cnt, cnt_nx, lfsr, lfsr_nx, src_lfsr, src_cnt;
    logic [CH*WIDTH-1:0]   x_reg, x_nx, src_x;
    logic                  mode_reg, mode_nx, src_mode;
    logic                  emit;
    logic [CH-1:0]         bits;

    // A start seen while the done pulse is up emits bit 0 of the new stream
    // straight from the inputs, so back-to-back streams have no gap.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lfsr_nx  = lfsr;
        x_nx     = x_reg;
        mode_nx  = mode_reg;
        emit     = 1'b0;
        src_x    = x_reg;
        src_mode = mode_reg;
        src_lfsr = lfsr;
        src_cnt  = cnt;
        case (state)
            IDLE: begin
                if (i_start_sng && !i_stop_sng) begin
                    state_nx = RUN;
                    x_nx     = i_x_bn;
                    mode_nx  = i_mode_sng;
                    if (o_done_sng) begin
                        emit     = 1'b1;
                        src_x    = i_x_bn;
                        src_mode = i_mode_sng;
                        src_lfsr = SEED_V;
                        src_cnt  = '0;
                        cnt_nx   = WIDTH'(1);
                        lfsr_nx  = lfsr_step(SEED_V);
                    end else begin
                        cnt_nx  = '0;
                        lfsr_nx = SEED_V;
                    end
                end
            end
            RUN: begin
                if (i_stop_sng) begin
                    state_nx = IDLE;
                end else begin
                    emit    = 1'b1;
                    cnt_nx  = cnt + WIDTH'(1);
                    lfsr_nx = lfsr_step(lfsr);
                    if (cnt == LAST)
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bits = '0;
        for (int k = 0; k < CH; k++)
            bits[k] = src_x[k*WIDTH +: WIDTH] >
                      (src_mode ? src_cnt : rotl(src_lfsr, k % WIDTH));
    end

    always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
        if (i_rst_sng) begin
            state       <= IDLE;
            cnt         <= '0;
            lfsr        <= SEED_V;
            x_reg       <= '0;
            mode_reg    <= 1'b0;
            o_sn_bits   <= '0;
            o_valid_sng <= 1'b0;
            o_done_sng  <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            lfsr        <= lfsr_nx;
            x_reg       <= x_nx;
            mode_reg    <= mode_nx;
            o_sn_bits   <= emit ? bits : '0;
            o_valid_sng <= emit;
            o_done_sng  <= emit && (src_cnt == LAST);
        end
    end

    assign o_busy_sng = (state == RUN);

endmodule

// File: tb/tb_sng_array.sv
// Scoreboard bench for sng_array: expected streams are queued at start time
// and popped as valid bits appear, across three parameter sets.
module tb_sng_array;

    localparam int SEED = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] bits;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        start = 0, stop = 0, mode = 0;
    logic [15:0] x = '0;
    logic [3:0]  sn;
    logic        valid, done, busy;

    logic        start3 = 0, stop3 = 0, mode3 = 0;
    logic [2:0]  x3 = '0;
    logic [0:0]  sn3;
    logic        valid3, done3, busy3;

    logic         start8 = 0, stop8 = 0, mode8 = 0;
    logic [127:0] x8 = '0;
    logic [15:0]  sn8;
    logic         valid8, done8, busy8;

    sng_array #(.WIDTH(4), .CH(4), .SEED(SEED)) dut (
        .i_clk_sng(clk), .i_rst_sng(rst), .i_start_sng(start), .i_stop_sng(stop),
        .i_mode_sng(mode), .i_x_bn(x), .o_sn_bits(sn), .o_valid_sng(valid),
        .o_done_sng(done), .o_busy_sng(busy));

    sng_array #(.WIDTH(3), .CH(1), .SEED(SEED)) dut3 (
        .i_clk_sng(clk), .i_rst_sng(rst), .i_start_sng(start3), .i_stop_sng(stop3),
        .i_mode_sng(mode3), .i_x_bn(x3), .o_sn_bits(sn3), .o_valid_sng(valid3),
        .o_done_sng(done3), .o_busy_sng(busy3));

    sng_array #(.WIDTH(8), .CH(16), .SEED(SEED)) dut8 (
        .i_clk_sng(clk), .i_rst_sng(rst), .i_start_sng(start8), .i_stop_sng(stop8),
        .i_mode_sng(mode8), .i_x_bn(x8), .o_sn_bits(sn8), .o_valid_sng(valid8),
        .o_done_sng(done8), .o_busy_sng(busy8));

    // Reference LFSR written directly from the tap table and zero-splice rule.
    function automatic int lfsr_ref(int w, int s);
        int taps, mask, fb;
        case (w)
            3: taps = 'h06;
            4: taps = 'h0C;
            5: taps = 'h14;
            6: taps = 'h30;
            7: taps = 'h60;
            default: taps = 'hB8;
        endcase
        mask = (1 << w) - 1;
        fb = ($countones(s & taps) & 1) ^ (((s & (mask >> 1)) == 0) ? 1 : 0);
        return ((s << 1) & mask) | fb;
    endfunction

    function automatic int rotl_ref(int w, int v, int sh);
        if (sh == 0) return v;
        return ((v << sh) | (v >> (w - sh))) & ((1 << w) - 1);
    endfunction

    function automatic logic [15:0] model_bits(int w, int ch, logic [127:0] xv, bit m, int r);
        logic [15:0] b;
        int xk, rr;
        b = '0;
        for (int k = 0; k < ch; k++) begin
            xk = 0;
            for (int i = 0; i < w; i++) xk = xk | (int'(xv[k*w+i]) << i);
            rr = m ? r : rotl_ref(w, r, k % w);
            b[k] = (xk > rr);
        end
        return b;
    endfunction

    function automatic logic [127:0] rep(int w, int ch, int v);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < ch; k++)
            for (int i = 0; i < w; i++) r[k*w+i] = v[i];
        return r;
    endfunction

    task automatic push_stream(int w, int ch, logic [127:0] xv, bit m);
        int s;
        exp_t e;
        s = SEED;
        for (int n = 0; n < (1 << w); n++) begin
            e.bits = model_bits(w, ch, xv, m, m ? n : s);
            e.done = (n == (1 << w) - 1);
            exp_q.push_back(e);
            s = lfsr_ref(w, s);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({sn, valid, done, busy} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_w4: got sn=%b v=%b d=%b b=%b, expected all 0", sn, valid, done, busy);
        end
        checks++;
        if ({sn3, valid3, done3, busy3, sn8, valid8, done8, busy8} !== 23'b0) begin
            errors++;
            $display("[TB] FAIL reset_corners: got sn3=%b sn8=%h v3=%b v8=%b, expected 0", sn3, sn8, valid3, valid8);
        end
        rst = 1'b0;
    endtask

    task automatic test_ramp;
        exp_t e;
        int cyc, n;
        bit gap;
        logic [15:0] xt;
        @(negedge clk);
        x = {4'd8, 4'd15, 4'd5, 4'd0};
        mode = 1'b1;
        start = 1'b1;
        push_stream(4, 4, {112'b0, x}, 1'b1);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ramp_latency: got busy=%b valid=%b, expected busy=1 valid=0", busy, valid);
        end
        cyc = 0; n = 0; gap = 0;
        while (exp_q.size() > 0 && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({sn, done} !== {e.bits[3:0], e.done}) begin
                    errors++;
                    $display("[TB] FAIL ramp_bit %0d: got sn=%b done=%b, expected sn=%b done=%b", n, sn, done, e.bits[3:0], e.done);
                end
                n++;
            end else if (n > 0) gap = 1;
        end
        checks++;
        if (exp_q.size() != 0 || gap || n != 16) begin
            errors++;
            $display("[TB] FAIL ramp_length: got %0d bits gap=%0d, expected 16 contiguous", n, gap);
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || sn !== 4'b0) begin
            errors++;
            $display("[TB] FAIL ramp_idle: got valid=%b busy=%b sn=%b, expected 0", valid, busy, sn);
        end
        xt = x;
        x = ~xt;
    endtask

    task automatic test_lfsr_sweep;
        exp_t e;
        int cyc, n, r;
        int ones[4];
        int ones_at[16];
        logic [15:0] s5[4];
        logic [15:0] seen;
        logic [127:0] xv;
        bit bad;
        for (int i = 0; i < 16; i++) ones_at[i] = 0;
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            xv = rep(4, 4, v);
            x = xv[15:0];
            mode = 1'b0;
            start = 1'b1;
            push_stream(4, 4, xv, 1'b0);
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 4; k++) ones[k] = 0;
            cyc = 0; n = 0;
            while (exp_q.size() > 0 && cyc < 64) begin
                @(negedge clk);
                cyc++;
                if (valid) begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({sn, done} !== {e.bits[3:0], e.done}) begin
                        errors++;
                        $display("[TB] FAIL lfsr x=%0d bit %0d: got sn=%b done=%b, expected sn=%b done=%b", v, n, sn, done, e.bits[3:0], e.done);
                    end
                    for (int k = 0; k < 4; k++) begin
                        ones[k] += int'(sn[k]);
                        if (v == 5) s5[k][n] = sn[k];
                    end
                    ones_at[n] += int'(sn[0]);
                    n++;
                end
            end
            if (exp_q.size() != 0) begin
                checks++; errors++;
                $display("[TB] FAIL lfsr_timeout x=%0d: got %0d bits, expected 16", v, n);
                exp_q.delete();
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ones[k] != v) begin
                    errors++;
                    $display("[TB] FAIL lfsr_popcount x=%0d ch%0d: got %0d, expected %0d", v, k, ones[k], v);
                end
            end
        end
        bad = 0;
        for (int a = 0; a < 4; a++)
            for (int b = a + 1; b < 4; b++)
                if (s5[a] == s5[b]) bad = 1;
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL decorrelation x=5: got %h %h %h %h, expected pairwise distinct", s5[0], s5[1], s5[2], s5[3]);
        end
        seen = '0; bad = 0;
        for (int i = 0; i < 16; i++) begin
            r = 15 - ones_at[i];
            if (r < 0 || r > 15) bad = 1;
            else begin
                if (seen[r]) bad = 1;
                seen[r] = 1'b1;
            end
        end
        checks++;
        if (bad || seen !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL period_w4: got visited=%h, expected ffff each once", seen);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int cyc, n, ones2;
        bit gap, restarted;
        logic [127:0] xv;
        @(negedge clk);
        xv = rep(4, 4, 9);
        x = xv[15:0];
        mode = 1'b0;
        start = 1'b1;
        push_stream(4, 4, xv, 1'b0);
        cyc = 0; n = 0; gap = 0; restarted = 0; ones2 = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({sn, done} !== {e.bits[3:0], e.done}) begin
                    errors++;
                    $display("[TB] FAIL b2b_bit %0d: got sn=%b done=%b, expected sn=%b done=%b", n, sn, done, e.bits[3:0], e.done);
                end
                if (n >= 16) ones2 += $countones(sn);
                n++;
            end else if (n > 0) gap = 1;
            if (done && !restarted) begin
                restarted = 1;
                xv = rep(4, 4, 3);
                x = xv[15:0];
                start = 1'b1;
                push_stream(4, 4, xv, 1'b0);
            end
        end
        checks++;
        if (exp_q.size() != 0 || gap || n != 32) begin
            errors++;
            $display("[TB] FAIL b2b_length: got %0d bits gap=%0d, expected 32 contiguous", n, gap);
            exp_q.delete();
        end
        checks++;
        if (ones2 != 12) begin
            errors++;
            $display("[TB] FAIL b2b_popcount: got %0d ones over 4 channels, expected 12", ones2);
        end
        start = 1'b0;
    endtask

    task automatic test_abort;
        exp_t e;
        int cyc, n;
        bit bad;
        logic [127:0] xv;
        @(negedge clk);
        xv = rep(4, 4, 7);
        x = xv[15:0];
        mode = 1'b0;
        start = 1'b1;
        push_stream(4, 4, xv, 1'b0);
        @(negedge clk);
        start = 1'b0;
        cyc = 0; n = 0;
        while (n < 7 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({sn, done} !== {e.bits[3:0], e.done}) begin
                    errors++;
                    $display("[TB] FAIL abort_bit %0d: got sn=%b, expected sn=%b", n, sn, e.bits[3:0]);
                end
                n++;
            end
        end
        exp_q.delete();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if ({valid, busy, done, sn} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL abort_stop: got valid=%b busy=%b done=%b sn=%b, expected 0", valid, busy, done, sn);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || valid || busy) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL abort_quiet: got activity after abort, expected none");
        end
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || valid || busy) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL start_with_stop: got stream activity, expected start ignored");
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        int cyc, n;
        logic [127:0] xv;
        xv = rep(4, 4, 10);
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            x = xv[15:0];
            mode = 1'b0;
            start = 1'b1;
            push_stream(4, 4, xv, 1'b0);
            @(negedge clk);
            start = 1'b0;
            cyc = 0; n = 0;
            while (exp_q.size() > 0 && cyc < 64 && !(pass == 0 && n == 5)) begin
                @(negedge clk);
                cyc++;
                if (valid) begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({sn, done} !== {e.bits[3:0], e.done}) begin
                        errors++;
                        $display("[TB] FAIL areset pass%0d bit %0d: got sn=%b, expected sn=%b", pass, n, sn, e.bits[3:0]);
                    end
                    n++;
                end
            end
            if (pass == 0) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({valid, busy, done, sn} !== 7'b0) begin
                    errors++;
                    $display("[TB] FAIL areset_outputs: got valid=%b busy=%b done=%b sn=%b, expected 0", valid, busy, done, sn);
                end
                exp_q.delete();
                @(negedge clk);
                rst = 1'b0;
            end else begin
                checks++;
                if (exp_q.size() != 0 || n != 16) begin
                    errors++;
                    $display("[TB] FAIL areset_rerun: got %0d bits, expected 16", n);
                    exp_q.delete();
                end
            end
        end
    endtask

    task automatic test_corner_w3;
        exp_t e;
        int cyc, n, ones, r;
        int ones_at[8];
        logic [7:0] seen;
        bit bad;
        for (int i = 0; i < 8; i++) ones_at[i] = 0;
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            x3 = 3'(v);
            mode3 = 1'b0;
            start3 = 1'b1;
            push_stream(3, 1, {125'b0, x3}, 1'b0);
            @(negedge clk);
            start3 = 1'b0;
            cyc = 0; n = 0; ones = 0;
            while (exp_q.size() > 0 && cyc < 32) begin
                @(negedge clk);
                cyc++;
                if (valid3) begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({sn3, done3} !== {e.bits[0], e.done}) begin
                        errors++;
                        $display("[TB] FAIL w3 x=%0d bit %0d: got sn=%b done=%b, expected sn=%b done=%b", v, n, sn3, done3, e.bits[0], e.done);
                    end
                    ones += int'(sn3[0]);
                    ones_at[n] += int'(sn3[0]);
                    n++;
                end
            end
            checks++;
            if (exp_q.size() != 0 || n != 8 || ones != v) begin
                errors++;
                $display("[TB] FAIL w3_stream x=%0d: got %0d bits %0d ones, expected 8 bits %0d ones", v, n, ones, v);
                exp_q.delete();
            end
        end
        seen = '0; bad = 0;
        for (int i = 0; i < 8; i++) begin
            r = 7 - ones_at[i];
            if (r < 0 || r > 7) bad = 1;
            else begin
                if (seen[r]) bad = 1;
                seen[r] = 1'b1;
            end
        end
        checks++;
        if (bad || seen !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL period_w3: got visited=%h, expected ff each once", seen);
        end
    endtask

    task automatic test_corner_w8;
        exp_t e;
        int cyc, n, vals[3], v;
        int ones[16];
        bit bad;
        vals[0] = 0; vals[1] = 1; vals[2] = 255;
        for (int j = 0; j < 3; j++) begin
            v = vals[j];
            @(negedge clk);
            x8 = rep(8, 16, v);
            mode8 = 1'b0;
            start8 = 1'b1;
            push_stream(8, 16, x8, 1'b0);
            @(negedge clk);
            start8 = 1'b0;
            for (int k = 0; k < 16; k++) ones[k] = 0;
            cyc = 0; n = 0;
            while (exp_q.size() > 0 && cyc < 600) begin
                @(negedge clk);
                cyc++;
                if (valid8) begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({sn8, done8} !== {e.bits, e.done}) begin
                        errors++;
                        $display("[TB] FAIL w8 x=%0d bit %0d: got sn=%h done=%b, expected sn=%h done=%b", v, n, sn8, done8, e.bits, e.done);
                    end
                    for (int k = 0; k < 16; k++) ones[k] += int'(sn8[k]);
                    n++;
                end
            end
            bad = (exp_q.size() != 0) || (n != 256);
            for (int k = 0; k < 16; k++) if (ones[k] != v) bad = 1;
            checks++;
            if (bad) begin
                errors++;
                $display("[TB] FAIL w8_stream x=%0d: got %0d bits ch0 ones=%0d, expected 256 bits %0d ones per channel", v, n, ones[0], v);
                exp_q.delete();
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_lfsr_sweep();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_corner_w3();
        test_corner_w8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
